instr_cycle_controller: RTL and testbench
=========================================

Name: instr_cycle_controller

Overview:
- Single-clock sequencer for the instruction cycle around the EIP.
- Owns the EIP value.
- Runs FETCH, then DECODE, then EXEC, then UPDATE, with a memory fetch handshake, a decoder length input, an execute-done handshake, and branch redirect.
- Sits between the instruction memory port, the opcode decoder and the execute unit. It replaces the free-running multi-phase increment with an explicit state machine.

Parameters:
- RESET_EIP, 32'h00000050, EIP value loaded on reset.
- MAX_LEN, 6, largest legal instruction length in bytes.
- FETCH_TIMEOUT, 16, cycles FETCH may wait for fetch_ack before faulting (range 1..255).

Ports:
- clock_4  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  leaves IDLE or HALT.
- fetch_req  out  1  memory read request.
- fetch_addr  out  32  read address; always equals eip.
- fetch_ack  in  1  memory read complete; fetch_data valid this cycle.
- fetch_data  in  8  opcode byte.
- op_len  in  4  instruction length from decoder, valid during DECODE.
- exec_start  out  1  one-cycle pulse starting the execute unit.
- exec_done  in  1  execute finished; branch inputs valid this cycle.
- branch_taken  in  1  redirect EIP to branch_target.
- branch_target  in  32  jump destination.
- halt_req  in  1  stop after the current instruction.
- eip  out  32  current instruction pointer.
- opcode  out  8  latched opcode.
- state  out  3  encoded FSM state.
- fault  out  1  sticky fault flag.
- fault_code  out  2  0 none, 1 fetch timeout, 2 illegal length.
- instr_count  out  32  retired instruction count.

Behaviour:
- Reset (synchronous, clock_4 edge with reset=1; overrides everything, including mid-fetch and mid-exec):
  - state=IDLE, eip=RESET_EIP, opcode=0, instr_count=0.
  - fault=0, fault_code=0, fetch_req=0, exec_start=0, timeout counter=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, UPDATE=4, HALT=5, FAULT=6.
- IDLE:
  - outputs quiescent.
  - start=1 -> FETCH next cycle.
- FETCH:
  - fetch_req=1; fetch_addr=eip, held stable.
  - fetch_ack=1 -> latch opcode<=fetch_data, go to DECODE, clear the timeout counter.
  - Otherwise the counter increments. When it reaches FETCH_TIMEOUT without ack -> FAULT, fault_code=1.
  - An ack in the same cycle the counter hits the limit wins: go to DECODE.
- DECODE:
  - exactly one cycle; op_len sampled and latched as len.
  - 1<=op_len<=MAX_LEN -> EXEC.
  - otherwise (0 or >MAX_LEN) -> FAULT, fault_code=2.
- EXEC:
  - exec_start=1 only in the first EXEC cycle.
  - Wait for exec_done. exec_done is accepted in the first cycle too.
  - On exec_done, latch branch_taken and branch_target -> UPDATE.
- UPDATE (one cycle):
  - eip <= branch_taken_latched ? branch_target_latched : eip + len (32-bit unsigned, wraps modulo 2^32).
  - instr_count <= instr_count + 1 (wraps).
  - Next state: halt_req=1 -> HALT, else FETCH.
- HALT:
  - quiescent.
  - start=1 -> FETCH (eip retained).
- FAULT:
  - fault=1; all handshake outputs 0; eip frozen.
  - Exited only by reset. start is ignored.
- Ignored inputs:
  - fetch_ack outside FETCH, exec_done outside EXEC, start outside IDLE/HALT.
  - halt_req outside UPDATE; it is level-sampled.
- Minimum instruction latency is 4 cycles: ack in the first FETCH cycle, plus DECODE, plus EXEC with done in the same cycle, plus UPDATE.
- eip changes only in UPDATE or on reset.

Decomposition:
- Shared package: state encoding constants, fault_code constants, RESET_EIP default.
- Sub-module fetch_timeout_counter: 8-bit counter with clear, enable and limit-hit flag.
- The FSM and datapath stay in the top module.

Test Plan:
- Reset then start; fetch_ack on the first FETCH cycle, fetch_data=8'h90, op_len=1, exec_done on the first EXEC cycle, no branch.
  - Expect eip 0x50 -> 0x51 after 4 cycles, instr_count=1, and fetch_addr=0x50 during FETCH.
- Branch case: op_len=5, exec_done with branch_taken=1, branch_target=32'h00000027.
  - Expect eip=0x27 after UPDATE, and the next fetch_addr=0x27.
- Illegal lengths: op_len=0, and separately op_len=7.
  - Expect FAULT, fault=1, fault_code=2, eip unchanged.
  - start is ignored; only reset clears the fault.
- Fetch timeout: hold fetch_ack=0 for 16 cycles.
  - Expect FAULT with fault_code=1.
  - Repeat with ack arriving in cycle 16; expect DECODE.
- Halt and resume: halt_req=1 during UPDATE.
  - Expect HALT with eip held.
  - Pulse start; expect FETCH at the updated eip.
- Wrap and mid-operation reset:
  - Branch to 32'hFFFFFFFE with op_len=3; the next instruction yields eip=32'h00000001.
  - Assert reset during EXEC; expect IDLE, eip=0x50, instr_count=0 on the next edge.

Source files
------------

// File: rtl/instr_cycle_controller_pkg.sv
// Shared encodings for the instruction-cycle sequencer.
// Holds state and fault-code constants, the reset EIP default and the length legality check.
package instr_cycle_controller_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_UPDATE = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;
   localparam logic [2:0] ST_FAULT  = 3'd6;

   localparam logic [1:0] FC_NONE          = 2'd0;
   localparam logic [1:0] FC_FETCH_TIMEOUT = 2'd1;
   localparam logic [1:0] FC_ILLEGAL_LEN   = 2'd2;

   localparam logic [31:0] DEFAULT_RESET_EIP = 32'h0000_0050;

   function automatic logic len_legal(input logic [3:0] len, input logic [3:0] max_len);
      return (len != 4'd0) && (len <= max_len);
   endfunction

endpackage

// File: rtl/instr_cycle_controller_fetch_timeout_counter.sv
// Counts FETCH cycles spent waiting for the memory ack; single-cycle update, no backpressure.
// limit_hit flags that the increment happening this cycle reaches LIMIT.
module fetch_timeout_counter #(
   parameter logic [7:0] LIMIT = 8'd16
) (
   input  logic clock_4,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic limit_hit
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (enable) begin
         count_d = count_q + 8'd1;
      end
   end

   assign limit_hit = enable && ((count_q + 8'd1) == LIMIT);

   always_ff @(posedge clock_4) begin
      if (reset) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/instr_cycle_controller.sv
// FETCH/DECODE/EXEC/UPDATE sequencer owning the EIP; an instruction retires in 4 cycles minimum.
// Stalls in FETCH on fetch_ack (with timeout) and in EXEC on exec_done.
module instr_cycle_controller
   import instr_cycle_controller_pkg::*;
#(
   parameter logic [31:0] RESET_EIP     = DEFAULT_RESET_EIP,
   parameter int unsigned MAX_LEN       = 6,
   parameter int unsigned FETCH_TIMEOUT = 16
) (
   input  logic        clock_4,
   input  logic        reset,
   input  logic        start,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [7:0]  fetch_data,
   input  logic [3:0]  op_len,
   output logic        exec_start,
   input  logic        exec_done,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt_req,
   output logic [31:0] eip,
   output logic [7:0]  opcode,
   output logic [2:0]  state,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic [31:0] instr_count
);

   localparam logic [3:0] MAX_LEN_W = 4'(MAX_LEN);

   logic [2:0]  state_q, state_d;
   logic [31:0] eip_q, eip_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [3:0]  len_q, len_d;
   logic        br_taken_q, br_taken_d;
   logic [31:0] br_target_q, br_target_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        fault_q, fault_d;
   logic [1:0]  fault_code_q, fault_code_d;
   logic        exec_start_q, exec_start_d;

   logic cnt_enable;
   logic cnt_limit_hit;

   // Counter runs only while FETCH waits; any other cycle (or an ack) restarts it.
   assign cnt_enable = (state_q == ST_FETCH) && !fetch_ack;

   fetch_timeout_counter #(
      .LIMIT (8'(FETCH_TIMEOUT))
   ) u_fetch_timeout (
      .clock_4   (clock_4),
      .reset     (reset),
      .clear     (!cnt_enable),
      .enable    (cnt_enable),
      .limit_hit (cnt_limit_hit)
   );

   always_comb begin
      state_d       = state_q;
      eip_d         = eip_q;
      opcode_d      = opcode_q;
      len_d         = len_q;
      br_taken_d    = br_taken_q;
      br_target_d   = br_target_q;
      instr_count_d = instr_count_q;
      fault_d       = fault_q;
      fault_code_d  = fault_code_q;
      exec_start_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (fetch_ack) begin
               opcode_d = fetch_data;
               state_d  = ST_DECODE;
            end else if (cnt_limit_hit) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_FETCH_TIMEOUT;
            end
         end
         ST_DECODE: begin
            len_d = op_len;
            if (len_legal(op_len, MAX_LEN_W)) begin
               state_d      = ST_EXEC;
               exec_start_d = 1'b1;
            end else begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_ILLEGAL_LEN;
            end
         end
         ST_EXEC: begin
            if (exec_done) begin
               br_taken_d  = branch_taken;
               br_target_d = branch_target;
               state_d     = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            eip_d         = br_taken_q ? br_target_q : (eip_q + {28'd0, len_q});
            instr_count_d = instr_count_q + 32'd1;
            state_d       = halt_req ? ST_HALT : ST_FETCH;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_4) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         eip_q         <= RESET_EIP;
         opcode_q      <= 8'd0;
         len_q         <= 4'd0;
         br_taken_q    <= 1'b0;
         br_target_q   <= 32'd0;
         instr_count_q <= 32'd0;
         fault_q       <= 1'b0;
         fault_code_q  <= FC_NONE;
         exec_start_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         eip_q         <= eip_d;
         opcode_q      <= opcode_d;
         len_q         <= len_d;
         br_taken_q    <= br_taken_d;
         br_target_q   <= br_target_d;
         instr_count_q <= instr_count_d;
         fault_q       <= fault_d;
         fault_code_q  <= fault_code_d;
         exec_start_q  <= exec_start_d;
      end
   end

   assign fetch_req   = (state_q == ST_FETCH);
   assign fetch_addr  = eip_q;
   assign exec_start  = exec_start_q;
   assign eip         = eip_q;
   assign opcode      = opcode_q;
   assign state       = state_q;
   assign fault       = fault_q;
   assign fault_code  = fault_code_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_cycle_controller.sv
// Bench for instr_cycle_controller: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a behavioural model of the instruction cycle.
module tb_instr_cycle_controller;

   logic        clock_4;
   logic        reset;
   logic        start;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack;
   logic [7:0]  fetch_data;
   logic [3:0]  op_len;
   logic        exec_start;
   logic        exec_done;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halt_req;
   logic [31:0] eip;
   logic [7:0]  opcode;
   logic [2:0]  state;
   logic        fault;
   logic [1:0]  fault_code;
   logic [31:0] instr_count;

   instr_cycle_controller dut (
      .clock_4       (clock_4),
      .reset         (reset),
      .start         (start),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .fetch_ack     (fetch_ack),
      .fetch_data    (fetch_data),
      .op_len        (op_len),
      .exec_start    (exec_start),
      .exec_done     (exec_done),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt_req      (halt_req),
      .eip           (eip),
      .opcode        (opcode),
      .state         (state),
      .fault         (fault),
      .fault_code    (fault_code),
      .instr_count   (instr_count)
   );

   initial begin
      clock_4 = 1'b0;
      forever #5 clock_4 = ~clock_4;
   end

   int n_total = 0;
   int n_bad   = 0;

   // Behavioural model: phase names from the instruction cycle, plain counters for waits.
   int          m_phase;      // 0 idle,1 fetch,2 decode,3 exec,4 update,5 halt,6 fault
   bit          m_valid = 0;
   logic [31:0] m_eip;
   logic [7:0]  m_op;
   int          m_len;
   bit          m_bt;
   logic [31:0] m_btgt;
   logic [31:0] m_retired;
   bit          m_fault;
   int          m_fcode;
   int          m_fetch_wait;
   int          m_exec_cycles;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_valid = 1; m_phase = 0; m_eip = 32'h50; m_op = 8'h00; m_retired = 0;
         m_fault = 0; m_fcode = 0; m_fetch_wait = 0; m_exec_cycles = 0;
         m_len = 0; m_bt = 0; m_btgt = 0;
      end else if (m_valid) begin
         case (m_phase)
            0, 5: if (start) begin m_phase = 1; m_fetch_wait = 0; end
            1: begin
               if (fetch_ack) begin
                  m_op = fetch_data; m_phase = 2; m_fetch_wait = 0;
               end else begin
                  m_fetch_wait++;
                  if (m_fetch_wait >= 16) begin m_phase = 6; m_fault = 1; m_fcode = 1; end
               end
            end
            2: begin
               m_len = int'(op_len);
               if (m_len >= 1 && m_len <= 6) begin m_phase = 3; m_exec_cycles = 0; end
               else begin m_phase = 6; m_fault = 1; m_fcode = 2; end
            end
            3: begin
               m_exec_cycles++;
               if (exec_done) begin m_bt = branch_taken; m_btgt = branch_target; m_phase = 4; end
            end
            4: begin
               m_eip = m_bt ? m_btgt : m_eip + 32'(m_len);
               m_retired = m_retired + 1;
               m_phase = halt_req ? 5 : 1;
               m_fetch_wait = 0;
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare_all();
      if (m_valid) begin
         chk("state", 32'(state), 32'(m_phase));
         chk("eip", eip, m_eip);
         chk("fetch_addr", fetch_addr, m_eip);
         chk("fetch_req", 32'(fetch_req), 32'(m_phase == 1));
         chk("exec_start", 32'(exec_start), 32'(m_phase == 3 && m_exec_cycles == 0));
         chk("opcode", 32'(opcode), 32'(m_op));
         chk("fault", 32'(fault), 32'(m_fault));
         chk("fault_code", 32'(fault_code), 32'(m_fcode));
         chk("instr_count", instr_count, m_retired);
      end
   endtask

   task automatic tick();
      @(posedge clock_4);
      model_step();
      @(negedge clock_4);
      compare_all();
   endtask

   task automatic idle_inputs();
      reset = 0; start = 0; fetch_ack = 0; fetch_data = 8'h00; op_len = 4'd0;
      exec_done = 0; branch_taken = 0; branch_target = 32'h0; halt_req = 0;
   endtask

   // Runs one instruction from FETCH (ack at once) to the cycle after UPDATE.
   task automatic run_instr(input logic [3:0] len, input bit bt, input logic [31:0] tgt);
      fetch_ack = 1; fetch_data = 8'h90; tick();
      fetch_ack = 0; op_len = len; tick();
      exec_done = 1; branch_taken = bt; branch_target = tgt; tick();
      exec_done = 0; branch_taken = 0; tick();
   endtask

   initial begin
      idle_inputs();

      // Reset state
      reset = 1; tick(); reset = 0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_eip", eip, 32'h50);
      chk("rst_count", instr_count, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);

      // First instruction, no branch
      start = 1; tick(); start = 0;
      chk("first_fetch_addr", fetch_addr, 32'h50);
      chk("first_fetch_req", 32'(fetch_req), 32'd1);
      fetch_ack = 1; fetch_data = 8'h90; tick(); fetch_ack = 0;
      chk("first_opcode", 32'(opcode), 32'h90);
      op_len = 4'd1; tick();
      chk("first_exec_start", 32'(exec_start), 32'd1);
      exec_done = 1; tick(); exec_done = 0;
      chk("first_update", 32'(state), 32'd4);
      tick();
      chk("first_eip", eip, 32'h51);
      chk("first_count", instr_count, 32'd1);

      // Branch
      run_instr(4'd5, 1'b1, 32'h27);
      chk("branch_eip", eip, 32'h27);
      chk("branch_fetch_addr", fetch_addr, 32'h27);

      // Illegal length 0, start ignored while faulted
      fetch_ack = 1; tick(); fetch_ack = 0; op_len = 4'd0; tick();
      chk("len0_fault", 32'(fault), 32'd1);
      chk("len0_code", 32'(fault_code), 32'd2);
      chk("len0_eip", eip, 32'h27);
      start = 1; tick(); start = 0;
      chk("fault_start_ignored", 32'(state), 32'd6);
      reset = 1; tick(); reset = 0;
      chk("fault_cleared", 32'(fault), 32'd0);

      // Illegal length 7
      start = 1; tick(); start = 0;
      fetch_ack = 1; tick(); fetch_ack = 0; op_len = 4'd7; tick();
      chk("len7_code", 32'(fault_code), 32'd2);
      chk("len7_eip", eip, 32'h50);
      reset = 1; tick(); reset = 0;

      // Fetch timeout: 16 cycles without ack
      start = 1; tick(); start = 0;
      repeat (15) tick();
      chk("timeout_still_fetch", 32'(state), 32'd1);
      tick();
      chk("timeout_state", 32'(state), 32'd6);
      chk("timeout_code", 32'(fault_code), 32'd1);
      reset = 1; tick(); reset = 0;

      // Ack in the 16th cycle wins
      start = 1; tick(); start = 0;
      repeat (15) tick();
      fetch_ack = 1; tick(); fetch_ack = 0;
      chk("late_ack_decode", 32'(state), 32'd2);

      // Halt and resume
      op_len = 4'd2; tick();
      exec_done = 1; tick(); exec_done = 0;
      halt_req = 1; tick(); halt_req = 0;
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_eip", eip, 32'h52);
      tick();
      chk("halt_held", 32'(state), 32'd5);
      start = 1; tick(); start = 0;
      chk("resume_fetch", 32'(state), 32'd1);
      chk("resume_addr", fetch_addr, 32'h52);

      // Wrap modulo 2^32
      run_instr(4'd1, 1'b1, 32'hFFFF_FFFE);
      chk("wrap_target", eip, 32'hFFFF_FFFE);
      run_instr(4'd3, 1'b0, 32'h0);
      chk("wrap_eip", eip, 32'h0000_0001);

      // Reset during EXEC
      fetch_ack = 1; tick(); fetch_ack = 0; op_len = 4'd1; tick();
      chk("mid_exec", 32'(state), 32'd3);
      reset = 1; tick(); reset = 0;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_eip", eip, 32'h50);
      chk("mid_rst_count", instr_count, 32'd0);

      // Random traffic; ack probability varies so timeouts also occur
      for (int blk = 0; blk < 12; blk++) begin
         int ack_pct;
         ack_pct = (blk % 3 == 2) ? 4 : 40;
         for (int c = 0; c < 250; c++) begin
            reset         = ($urandom_range(0, 99) < 2);
            start         = ($urandom_range(0, 3) == 0);
            fetch_ack     = ($urandom_range(0, 99) < ack_pct);
            fetch_data    = 8'($urandom);
            op_len        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15))
                                                         : 4'($urandom_range(0, 6));
            exec_done     = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 4)))
                                                         : 32'($urandom);
            halt_req      = ($urandom_range(0, 3) == 0);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
